// File: rtl/lfsr_sng_bank.sv
// lfsr_sng_bank: one Fibonacci LFSR feeding N_CH rotating windows, each compared
// against a per-channel probability to emit one stochastic bit per cycle, with a
// stream controller that frames exactly STREAM_LEN samples per START.
// Optional build macro: LFSR_LOCKUP_GUARD_EN (replace an all-zero next state by RST_SEED).
module lfsr_sng_bank #(
    parameter int unsigned    W          = 16,
    parameter logic [W-1:0]   TAP_MASK   = W'(16'h8016),
    parameter logic [W-1:0]   RST_SEED   = W'(16'hACE1),
    parameter int unsigned    N_CH       = 16,
    parameter int unsigned    OUT_W      = 8,
    parameter int unsigned    STRIDE     = 1,
    parameter int unsigned    STREAM_LEN = 256,
    parameter int unsigned    CNT_W      = $clog2(STREAM_LEN + 1)
) (
    input  logic                    TRIG,
    input  logic                    RESET,
    input  logic                    EN,
    input  logic                    SEED_LD,
    input  logic [W-1:0]            SEED,
    input  logic                    START,
    input  logic [N_CH*OUT_W-1:0]   PROB,
    output logic [N_CH*OUT_W-1:0]   RND,
    output logic [N_CH-1:0]         BITS,
    output logic                    BIT_VLD,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [CNT_W-1:0]        CNT
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [W-1:0]    d;
    logic [W-1:0]    d_adv;
    logic [W-1:0]    d_pre;
    logic [W-1:0]    d_nxt;
    logic            fb;
    logic            last;
    logic [N_CH-1:0] hit;

    // Fibonacci feedback and one-step advance
    assign fb    = ^(d & TAP_MASK);
    assign d_adv = {d[W-2:0], fb};

    // Next LFSR state: seed load wins over advance; otherwise hold
    always_comb begin
        d_pre = d;
        if (SEED_LD) begin
            d_pre = SEED;
        end else if (EN) begin
            d_pre = d_adv;
        end
    end

`ifdef LFSR_LOCKUP_GUARD_EN
    // Never let the register settle in the all-zero lockup state
    assign d_nxt = (d_pre == '0) ? RST_SEED : d_pre;
`else
    assign d_nxt = d_pre;
`endif

    // Rotating windows (wrapping around the register) and per-channel compare
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        for (genvar i = 0; i < OUT_W; i++) begin : g_bit
            localparam int unsigned SRC = (k * STRIDE + i) % W;
            assign RND[k*OUT_W + i] = d[SRC];
        end
        assign hit[k] = RND[k*OUT_W +: OUT_W] < PROB[k*OUT_W +: OUT_W];
    end

    assign last = (CNT == CNT_W'(STREAM_LEN - 1));
    assign BUSY = (state == S_RUN);

    // LFSR state, stream FSM and registered sample outputs
    always_ff @(posedge TRIG or negedge RESET) begin
        if (!RESET) begin
            d       <= RST_SEED;
            state   <= S_IDLE;
            BITS    <= '0;
            BIT_VLD <= 1'b0;
            DONE    <= 1'b0;
            CNT     <= '0;
        end else begin
            d       <= d_nxt;
            BIT_VLD <= 1'b0;
            DONE    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!SEED_LD && START) begin
                        state <= S_RUN;
                        CNT   <= '0;
                    end
                end
                S_RUN: begin
                    if (SEED_LD) begin
                        state <= S_IDLE;
                        CNT   <= '0;
                    end else if (EN) begin
                        BITS    <= hit;
                        BIT_VLD <= 1'b1;
                        CNT     <= CNT + CNT_W'(1);
                        if (last) begin
                            DONE  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_sng_bank.sv
// tb_lfsr_sng_bank: scoreboard bench for lfsr_sng_bank (default parameters).
module tb_lfsr_sng_bank;

    localparam int unsigned W     = 16;
    localparam int unsigned N_CH  = 16;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned STRIDE = 1;
    localparam int unsigned LEN   = 256;
    localparam int unsigned CNT_W = 9;
    localparam int unsigned PW    = N_CH * OUT_W;

    logic             TRIG = 1'b0;
    logic             RESET;
    logic             EN;
    logic             SEED_LD;
    logic [W-1:0]     SEED;
    logic             START;
    logic [PW-1:0]    PROB;
    logic [PW-1:0]    RND;
    logic [N_CH-1:0]  BITS;
    logic             BIT_VLD;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] CNT;

    int checks   = 0;
    int failures = 0;

    logic [N_CH-1:0] sb[$];
    logic [N_CH-1:0] mon_exp;

    logic [W-1:0] m_d;
    logic         m_run;
    int           m_cnt;

    lfsr_sng_bank dut (
        .TRIG    (TRIG),
        .RESET   (RESET),
        .EN      (EN),
        .SEED_LD (SEED_LD),
        .SEED    (SEED),
        .START   (START),
        .PROB    (PROB),
        .RND     (RND),
        .BITS    (BITS),
        .BIT_VLD (BIT_VLD),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .CNT     (CNT)
    );

    always #5 TRIG = ~TRIG;

    function automatic logic [PW-1:0] rnd_of(input logic [W-1:0] d);
        logic [PW-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++)
            for (int i = 0; i < OUT_W; i++)
                r[k*OUT_W + i] = d[(k*STRIDE + i) % W];
        return r;
    endfunction

    function automatic logic [N_CH-1:0] bits_of(input logic [W-1:0] d, input logic [PW-1:0] p);
        logic [PW-1:0]   r;
        logic [N_CH-1:0] b;
        r = rnd_of(d);
        for (int k = 0; k < N_CH; k++)
            b[k] = r[k*OUT_W +: OUT_W] < p[k*OUT_W +: OUT_W];
        return b;
    endfunction

    function automatic logic [W-1:0] adv(input logic [W-1:0] d);
        logic [W-1:0] mask;
        mask = 16'h8016;
        return {d[W-2:0], ^(d & mask)};
    endfunction

    function automatic logic [W-1:0] guard(input logic [W-1:0] d);
`ifdef LFSR_LOCKUP_GUARD_EN
        return (d == '0) ? 16'hACE1 : d;
`else
        return d;
`endif
    endfunction

    // Drive one cycle, advance the reference model, push expected samples
    task automatic tick(input logic en, input logic sld, input logic [W-1:0] sd, input logic st);
        EN = en; SEED_LD = sld; SEED = sd; START = st;
        if (sld) begin
            if (m_run) m_cnt = 0;
            m_run = 1'b0;
            m_d = guard(sd);
        end else begin
            if (m_run) begin
                if (en) begin
                    sb.push_back(bits_of(m_d, PROB));
                    m_cnt++;
                    if (m_cnt == LEN) m_run = 1'b0;
                end
            end else if (st) begin
                m_run = 1'b1;
                m_cnt = 0;
            end
            if (en) m_d = guard(adv(m_d));
        end
        @(posedge TRIG);
        @(negedge TRIG);
        #1;
    endtask

    // Scoreboard: every valid sample must match the oldest expectation
    always @(negedge TRIG) begin
        if (RESET === 1'b1) begin
            if (BIT_VLD === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_vld bits=%h", BITS);
                end else begin
                    mon_exp = sb.pop_front();
                    if (BITS !== mon_exp) begin
                        failures++;
                        $display("FAIL sb_bits got=%h exp=%h t=%0t", BITS, mon_exp, $time);
                    end
                end
            end else if (sb.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL sb_missing_vld pending=%0d t=%0t", sb.size(), $time);
                sb.delete();
            end
        end
    end

    task automatic test_reset();
        RESET = 1'b0; EN = 1'b0; SEED_LD = 1'b0; SEED = '0; START = 1'b0; PROB = '0;
        @(negedge TRIG); #1;
        checks++;
        if (BITS !== '0 || BIT_VLD !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || CNT !== '0) begin
            failures++;
            $display("FAIL reset_outputs bits=%h vld=%b busy=%b done=%b cnt=%0d", BITS, BIT_VLD, BUSY, DONE, CNT);
        end
        checks++;
        if (RND !== rnd_of(16'hACE1)) begin
            failures++;
            $display("FAIL reset_rnd got=%h exp=%h", RND, rnd_of(16'hACE1));
        end
        m_d = 16'hACE1; m_run = 1'b0; m_cnt = 0;
        RESET = 1'b1;
    endtask

    task automatic test_step();
        tick(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (RND[7:0] !== 8'hC3) begin
            failures++;
            $display("FAIL step_ch0 got=%h exp=c3", RND[7:0]);
        end
        checks++;
        if (RND[9*OUT_W +: OUT_W] !== 8'hAC) begin
            failures++;
            $display("FAIL step_ch9 got=%h exp=ac", RND[9*OUT_W +: OUT_W]);
        end
        checks++;
        if (RND !== rnd_of(m_d)) begin
            failures++;
            $display("FAIL step_rnd got=%h exp=%h", RND, rnd_of(m_d));
        end
    endtask

    task automatic test_period();
        logic [W-1:0] d_obs;
        tick(1'b0, 1'b1, 16'hACE1, 1'b0);
        for (int n = 1; n <= 65535; n++) begin
            tick(1'b1, 1'b0, '0, 1'b0);
            d_obs = {RND[8*OUT_W +: OUT_W], RND[7:0]};
            checks++;
            if (d_obs === '0) begin
                failures++;
                $display("FAIL period_zero n=%0d", n);
            end
            if (n < 65535) begin
                checks++;
                if (d_obs === 16'hACE1) begin
                    failures++;
                    $display("FAIL period_early n=%0d got=%h", n, d_obs);
                end
            end else begin
                checks++;
                if (d_obs !== 16'hACE1) begin
                    failures++;
                    $display("FAIL period_return got=%h exp=ace1", d_obs);
                end
            end
        end
    endtask

    task automatic test_stream_zero();
        PROB = '0;
        tick(1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (BUSY !== 1'b1 || CNT !== '0) begin
            failures++;
            $display("FAIL zero_start busy=%b cnt=%0d exp busy=1 cnt=0", BUSY, CNT);
        end
        for (int i = 0; i < LEN; i++) begin
            tick(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (BIT_VLD !== 1'b1 || BITS !== '0 || DONE !== (i == LEN - 1) || CNT !== CNT_W'(i + 1)) begin
                failures++;
                $display("FAIL zero_sample i=%0d vld=%b bits=%h done=%b cnt=%0d", i, BIT_VLD, BITS, DONE, CNT);
            end
        end
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL zero_busy_end got=%b exp=0", BUSY);
        end
        tick(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (BIT_VLD !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL zero_after vld=%b done=%b exp 0 0", BIT_VLD, DONE);
        end
    endtask

    task automatic test_stream_half();
        int ones[N_CH];
        PROB = {N_CH{8'h80}};
        for (int k = 0; k < N_CH; k++) ones[k] = 0;
        tick(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < LEN; i++) begin
            tick(1'b1, 1'b0, '0, 1'b0);
            if (BIT_VLD === 1'b1)
                for (int k = 0; k < N_CH; k++) ones[k] += int'(BITS[k]);
        end
        for (int k = 0; k < N_CH; k++) begin
            checks++;
            if (ones[k] < 108 || ones[k] > 148) begin
                failures++;
                $display("FAIL half_density ch=%0d ones=%0d exp=108..148", k, ones[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [PW-1:0]    prev_rnd;
        logic [CNT_W-1:0] prev_cnt;
        int vld_n;
        vld_n = 0;
        for (int k = 0; k < N_CH; k++) PROB[k*OUT_W +: OUT_W] = 8'($urandom);
        tick(1'b0, 1'b0, '0, 1'b1);
        for (int c = 0; c < 2*LEN - 1; c++) begin
            prev_rnd = RND;
            prev_cnt = CNT;
            tick((c % 2) == 0, 1'b0, '0, 1'b0);
            if (BIT_VLD === 1'b1) vld_n++;
            if ((c % 2) != 0) begin
                checks++;
                if (CNT !== prev_cnt || RND !== prev_rnd || BIT_VLD !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold c=%0d cnt=%0d/%0d vld=%b", c, CNT, prev_cnt, BIT_VLD);
                end
            end
        end
        checks++;
        if (vld_n != LEN || DONE !== 1'b1 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL stall_end vld_n=%0d done=%b busy=%b exp 256 1 0", vld_n, DONE, BUSY);
        end
    endtask

    task automatic test_abort();
        int done_n;
        done_n = 0;
        for (int k = 0; k < N_CH; k++) PROB[k*OUT_W +: OUT_W] = 8'($urandom);
        tick(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 100; i++) tick(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (CNT !== CNT_W'(100)) begin
            failures++;
            $display("FAIL abort_pre_cnt got=%0d exp=100", CNT);
        end
        tick(1'b1, 1'b1, 16'h1234, 1'b0);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || CNT !== '0 || BIT_VLD !== 1'b0) begin
            failures++;
            $display("FAIL abort_state busy=%b done=%b cnt=%0d vld=%b", BUSY, DONE, CNT, BIT_VLD);
        end
        checks++;
        if (RND !== rnd_of(16'h1234)) begin
            failures++;
            $display("FAIL abort_seed got=%h exp=%h", RND, rnd_of(16'h1234));
        end
        tick(1'b0, 1'b1, 16'h5555, 1'b1);
        checks++;
        if (BUSY !== 1'b0 || RND !== rnd_of(16'h5555)) begin
            failures++;
            $display("FAIL start_with_seed busy=%b exp=0", BUSY);
        end
        tick(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < LEN; i++) begin
            tick(1'b1, 1'b0, '0, i == 10);
            if (DONE === 1'b1) done_n++;
            if (i == 10) begin
                checks++;
                if (CNT !== CNT_W'(11) || BUSY !== 1'b1) begin
                    failures++;
                    $display("FAIL start_in_run cnt=%0d busy=%b exp 11 1", CNT, BUSY);
                end
            end
        end
        checks++;
        if (done_n != 1 || DONE !== 1'b1 || BUSY !== 1'b0 || CNT !== CNT_W'(LEN)) begin
            failures++;
            $display("FAIL restart_end done_n=%0d done=%b busy=%b cnt=%0d", done_n, DONE, BUSY, CNT);
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, '0, 1'b0);
        RESET = 1'b0;
        #2;
        checks++;
        if (BUSY !== 1'b0 || CNT !== '0 || BIT_VLD !== 1'b0 || BITS !== '0 || RND !== rnd_of(16'hACE1)) begin
            failures++;
            $display("FAIL async_reset busy=%b cnt=%0d vld=%b bits=%h", BUSY, CNT, BIT_VLD, BITS);
        end
        sb.delete();
        m_d = 16'hACE1; m_run = 1'b0; m_cnt = 0;
        EN = 1'b0; START = 1'b0; SEED_LD = 1'b0;
        RESET = 1'b1;
    endtask

    task automatic test_zero_seed();
        PROB = {N_CH{8'h01}};
        tick(1'b0, 1'b1, '0, 1'b0);
`ifdef LFSR_LOCKUP_GUARD_EN
        checks++;
        if (RND !== rnd_of(16'hACE1)) begin
            failures++;
            $display("FAIL guard_reload got=%h exp=%h", RND, rnd_of(16'hACE1));
        end
        tick(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (RND !== rnd_of(16'h59C3)) begin
            failures++;
            $display("FAIL guard_advance got=%h exp=%h", RND, rnd_of(16'h59C3));
        end
`else
        tick(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (RND !== '0 || BIT_VLD !== 1'b1 || BITS !== {N_CH{1'b1}}) begin
                failures++;
                $display("FAIL zero_lock i=%0d rnd=%h vld=%b bits=%h", i, RND, BIT_VLD, BITS);
            end
        end
        tick(1'b0, 1'b1, 16'hACE1, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_step();
        test_period();
        test_stream_zero();
        test_stream_half();
        test_stall();
        test_abort();
        test_async_reset();
        test_zero_seed();
        tick(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover pending=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
